// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the sequential Booth multiplier family:
//               FSM state encoding, Booth recode pairs and a constant-time
//               clog2 helper for sizing counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // Controller states, 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Radix-2 Booth recode of the pair {P[1], P[0]}
   localparam logic [1:0] BOOTH_NOP = 2'b00;  // 11 is also a no-op
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Ceiling log2, minimum result 1 so a counter is never zero bits wide
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_booth_seq_signed_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth iteration. Recodes P[1:0],
//               adds/subtracts the multiplicand into the upper accumulator
//               (one guard bit wide) and arithmetic-shifts the whole P right
//               by one. Reusable by unrolled or higher-radix variants.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH_A = 6,
   parameter int WIDTH_B = 6
) (
   input  logic [WIDTH_A+WIDTH_B:0] i_p,
   input  logic [WIDTH_A-1:0]       i_a,
   output logic [WIDTH_A+WIDTH_B:0] o_p
);

   localparam int c_PW = WIDTH_A + WIDTH_B + 1;

   logic [WIDTH_A:0] w_acc;
   logic [WIDTH_A:0] w_a_ext;
   logic [WIDTH_A:0] w_sum;

   // One extra sign bit on both operands: negating -2^(WIDTH_A-1) stays exact
   assign w_acc   = {i_p[c_PW-1], i_p[c_PW-1:WIDTH_B+1]};
   assign w_a_ext = {i_a[WIDTH_A-1], i_a};

   // Booth recode and partial-product accumulate
   always_comb begin
      w_sum = w_acc;
      case (i_p[1:0])
         BOOTH_ADD: w_sum = w_acc + w_a_ext;
         BOOTH_SUB: w_sum = w_acc - w_a_ext;
         BOOTH_NOP: w_sum = w_acc;
         default:   w_sum = w_acc;
      endcase
   end

   // The guard bit becomes the new MSB, which is exactly the arithmetic shift
   assign o_p = {w_sum, i_p[WIDTH_B:1]};

endmodule : booth_step
`default_nettype wire

// File: rtl/mult_booth_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_seq_signed
// Description : Sequential radix-2 Booth signed multiplier, one Booth step
//               per clock, START/DONE handshake. Q and DONE are registered.
//               Optional macro MULT_BOOTH_ZERO_SKIP_EN: a zero operand skips
//               straight to FIN and returns Q=0 one cycle after START.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_seq_signed
   import mult_pkg::*;
#(
   parameter  int WIDTH_A = 6,
   parameter  int WIDTH_B = 6,
   localparam int WIDTH_Q = WIDTH_A + WIDTH_B
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               START,
   input  logic [WIDTH_A-1:0] A,
   input  logic [WIDTH_B-1:0] B,
   output logic               BUSY,
   output logic               DONE,
   output logic [WIDTH_Q-1:0] Q
);

   localparam int                 c_CNT_W    = clog2(WIDTH_B);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH_B - 1);

   localparam logic [1:0] c_ST_IDLE = IDLE;
   localparam logic [1:0] c_ST_CALC = CALC;
   localparam logic [1:0] c_ST_FIN  = FIN;

   logic [1:0]         r_state;
   logic [WIDTH_Q:0]   r_p;
   logic [WIDTH_A-1:0] r_a;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH_Q:0]   w_p_next;
   logic               w_zero_skip;

`ifdef MULT_BOOTH_ZERO_SKIP_EN
   assign w_zero_skip = (A == '0) || (B == '0);
`else
   assign w_zero_skip = 1'b0;
`endif

   booth_step #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B)
   ) u_booth_step (
      .i_p (r_p),
      .i_a (r_a),
      .o_p (w_p_next)
   );

   // Controller and datapath registers; reset aborts any operation in flight
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= c_ST_IDLE;
         r_p     <= '0;
         r_a     <= '0;
         r_cnt   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         Q       <= '0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (START) begin
                  r_a   <= A;
                  r_cnt <= '0;
                  if (w_zero_skip) begin
                     // Cleared P makes FIN publish a zero product
                     r_p     <= '0;
                     r_state <= c_ST_FIN;
                  end else begin
                     r_p     <= {{WIDTH_A{1'b0}}, B, 1'b0};
                     BUSY    <= 1'b1;
                     r_state <= c_ST_CALC;
                  end
               end
            end
            c_ST_CALC: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_CNT_LAST) begin
                  BUSY    <= 1'b0;
                  r_state <= c_ST_FIN;
               end
            end
            c_ST_FIN: begin
               Q       <= r_p[WIDTH_Q:1];
               DONE    <= 1'b1;
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule : mult_booth_seq_signed
`default_nettype wire

// File: tb/tb_mult_booth_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_booth_seq_signed
// Description : Self-checking bench for mult_booth_seq_signed: reset state,
//               directed corner products, latency/BUSY width, busy rejection,
//               held START throughput, async abort, asymmetric widths and an
//               exhaustive 6x6 sweep against the integer product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth_seq_signed;

   logic        clk;
   logic        n_rst;
   logic        start6, start8;
   logic [5:0]  a6, b6;
   logic [7:0]  a8;
   logic [3:0]  b8;
   logic        busy6, done6, busy8, done8;
   logic [11:0] q6, q8;

   int n_cmp = 0;
   int n_bad = 0;

   mult_booth_seq_signed #(.WIDTH_A(6), .WIDTH_B(6)) dut66 (
      .CLK(clk), .nRST(n_rst), .START(start6), .A(a6), .B(b6),
      .BUSY(busy6), .DONE(done6), .Q(q6)
   );

   mult_booth_seq_signed #(.WIDTH_A(8), .WIDTH_B(4)) dut84 (
      .CLK(clk), .nRST(n_rst), .START(start8), .A(a8), .B(b8),
      .BUSY(busy8), .DONE(done8), .Q(q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int a, input int b, input int wb);
`ifdef MULT_BOOTH_ZERO_SKIP_EN
      if (a == 0 || b == 0) return 1;
`endif
      return wb + 1;
   endfunction

   function automatic int exp_busy(input int a, input int b, input int wb);
`ifdef MULT_BOOTH_ZERO_SKIP_EN
      if (a == 0 || b == 0) return 0;
`endif
      return wb;
   endfunction

   // One operation on the selected instance; lat counts edges after START
   task automatic run_op(input bit sel, input int a, input int b,
                         output longint q, output int lat, output int busy_n);
      @(negedge clk);
      if (sel) begin start8 = 1'b1; a8 = 8'(a); b8 = 4'(b); end
      else     begin start6 = 1'b1; a6 = 6'(a); b6 = 6'(b); end
      @(negedge clk);
      start6 = 1'b0; start8 = 1'b0;
      a6 = 6'($urandom); b6 = 6'($urandom);
      a8 = 8'($urandom); b8 = 4'($urandom);
      lat = 0; busy_n = 0;
      while (!(sel ? done8 : done6) && lat < 40) begin
         if (sel ? busy8 : busy6) busy_n++;
         @(negedge clk);
         lat++;
      end
      q = sel ? longint'($signed(q8)) : longint'($signed(q6));
   endtask

   int tv_a [0:6] = '{-32, -32, 31,  5,   0, -1,   1};
   int tv_b [0:6] = '{-32,  31, 31, -3, -17, -1, -32};
   int tv_q [0:6] = '{1024, -992, 961, -15, 0, 1, -32};

   int as_a [0:2] = '{-128,   127, -128};
   int as_b [0:2] = '{  -8,    -8,    7};
   int as_q [0:2] = '{1024, -1016, -896};

   initial begin
      longint q;
      int lat, busy_n, extra, t, first, second;

      n_rst = 1'b1; start6 = 1'b0; start8 = 1'b0;
      a6 = '0; b6 = '0; a8 = '0; b8 = '0;
      #3 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy6, 0);
      check("rst_done", done6, 0);
      check("rst_q",    q6,    0);
      check("rst_q84",  q8,    0);
      n_rst = 1'b1;

      // Directed corners, latency and BUSY width
      for (int i = 0; i < 7; i++) begin
         run_op(1'b0, tv_a[i], tv_b[i], q, lat, busy_n);
         check($sformatf("dir_q %0d*%0d", tv_a[i], tv_b[i]), q, tv_q[i]);
         check("dir_lat", lat, exp_lat(tv_a[i], tv_b[i], 6));
         check("dir_busy", busy_n, exp_busy(tv_a[i], tv_b[i], 6));
         @(negedge clk);
         check("dir_done_pulse", done6, 0);
      end

      // START while busy is ignored
      @(negedge clk);
      start6 = 1'b1; a6 = 6'(5); b6 = 6'(-3);
      @(negedge clk);
      start6 = 1'b0; lat = 0;
      while (!done6 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin start6 = 1'b1; a6 = 6'(7); b6 = 6'(7); end
         if (lat == 3) start6 = 1'b0;
      end
      check("rej_q", longint'($signed(q6)), -15);
      check("rej_lat", lat, 7);
      extra = 0;
      repeat (20) begin @(negedge clk); if (done6) extra++; end
      check("rej_no_second_done", extra, 0);
      check("rej_q_held", longint'($signed(q6)), -15);

      // START held high: one product per WIDTH_B+2 cycles
      @(negedge clk);
      start6 = 1'b1; a6 = 6'(3); b6 = 6'(-2);
      t = 0; first = -1; second = -1;
      while (second < 0 && t < 60) begin
         @(negedge clk);
         t++;
         if (done6) begin
            if (first < 0) first = t;
            else second = t;
         end
      end
      start6 = 1'b0;
      check("held_period", second - first, 8);
      check("held_q", longint'($signed(q6)), -6);

      // Async reset mid-operation
      @(negedge clk);
      start6 = 1'b1; a6 = 6'(9); b6 = 6'(9);
      @(negedge clk);
      start6 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", busy6, 1);
      #2 n_rst = 1'b0;
      #1;
      check("abort_busy", busy6, 0);
      check("abort_done", done6, 0);
      check("abort_q",    q6,    0);
      @(negedge clk);
      n_rst = 1'b1;
      extra = 0;
      repeat (20) begin @(negedge clk); if (done6) extra++; end
      check("abort_no_done", extra, 0);
      check("abort_idle_busy", busy6, 0);

      // Asymmetric widths 8x4
      for (int i = 0; i < 3; i++) begin
         run_op(1'b1, as_a[i], as_b[i], q, lat, busy_n);
         check($sformatf("asym_q %0d*%0d", as_a[i], as_b[i]), q, as_q[i]);
         check("asym_lat", lat, 5);
         check("asym_busy", busy_n, 4);
      end

      // Exhaustive 6x6 sweep
      for (int ai = -32; ai < 32; ai++) begin
         for (int bi = -32; bi < 32; bi++) begin
            run_op(1'b0, ai, bi, q, lat, busy_n);
            check($sformatf("exh_q %0d*%0d", ai, bi), q, longint'(ai * bi));
            check("exh_lat", lat, exp_lat(ai, bi, 6));
            check("exh_busy", busy_n, exp_busy(ai, bi, 6));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_mult_booth_seq_signed
`default_nettype wire

// File: doc/mult_booth_seq_signed.md
Name: mult_booth_seq_signed

Overview:
Sequential radix-2 Booth signed multiplier with a START/DONE handshake. It is the parametrised successor to the combinational signed LUT multiplier and supports independent operand widths. It trades latency for area: one Booth step per clock. It sits in the FPGA DSP datapath wherever a full-width combinational product is too large.

Parameters:
WIDTH_A, 6, width of signed multiplicand A (>=2)
WIDTH_B, 6, width of signed multiplier B (>=2); also the iteration count
WIDTH_Q, WIDTH_A+WIDTH_B, product width (derived localparam, not overridable)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
START  in  1  request; sampled only in IDLE
A  in  WIDTH_A  signed multiplicand, captured on accepted START
B  in  WIDTH_B  signed multiplier, captured on accepted START
BUSY  out  1  high from the cycle after an accepted START until DONE
DONE  out  1  single-cycle pulse, Q valid
Q  out  WIDTH_Q  signed product, held until the next DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; BUSY=0, DONE=0, Q=0; internal accumulator and counter cleared. A reset mid-operation aborts the operation, and no DONE is produced.
- FSM states: IDLE, CALC, FIN.
- IDLE with START=1 at edge t: capture A and B (sign-extended internally to WIDTH_Q+1); P={WIDTH_A zeros, B, 1'b0}; cnt=0; next=CALC.
- CALC: each cycle, examine P[1:0]:
  - 01: add A<<WIDTH_B
  - 10: subtract A<<WIDTH_B
  - 00 and 11: no operation
  - Then arithmetic right shift by 1 and increment cnt.
  - After WIDTH_B steps (cnt==WIDTH_B-1), next=FIN.
- FIN: Q<=P[WIDTH_Q:1]; DONE=1 for exactly this cycle; BUSY=0; next=IDLE.
- Latency: START sampled at edge t gives DONE high during cycle t+WIDTH_B+1. Back-to-back throughput is one product per WIDTH_B+2 cycles.
- START is ignored while BUSY or in FIN. No queuing occurs, and the operands are not recaptured.
- START held high continuously: a new operation starts in the cycle after FIN (IDLE re-entered, START sampled again).
- A and B may change freely after capture without affecting the result.
- Arithmetic: the accumulator is WIDTH_A+1 bits wide for the add/sub so that negating -2^(WIDTH_A-1) cannot overflow. The result is exact for all inputs, including (-2^(WIDTH_A-1))*(-2^(WIDTH_B-1)) = +2^(WIDTH_Q-2), with no saturation or wrap.
- Q and DONE are registered outputs; there is no combinational path from input to output.

Optional Feature:
- Macro: MULT_BOOTH_ZERO_SKIP_EN.
- Defined:
  - If captured A==0 or B==0, the FSM goes IDLE->FIN directly.
  - DONE is asserted in cycle t+1 with Q=0.
  - BUSY stays 0 for that operation.
  - All other operands behave exactly as without the macro.
- Undefined: every operation takes the full WIDTH_B+1 cycles to DONE, including zero operands.

Decomposition:
- Shared package mult_pkg holds:
  - FSM state enum (IDLE/CALC/FIN, 2-bit encoding)
  - Booth recode constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB)
  - function clog2 used to size cnt as clog2(WIDTH_B)
- One natural sub-module: booth_step. It is combinational: it takes {P, A} and returns the next P, covering recode, add/sub and arithmetic shift. It is reusable by a future radix-4 or unrolled variant.

Test Plan:
- Exhaustive, WIDTH_A=WIDTH_B=6: for every A,B in [-32,31], pulse START, wait for DONE -> Q equals the reference product A*B. DONE is seen exactly 7 cycles after START, and BUSY is high for 6 cycles.
- Corner values: A=-32, B=-32 -> Q=+1024 (0x400). A=-32, B=31 -> Q=-992. A=31, B=31 -> Q=961.
- Busy rejection: START with A=5, B=-3; pulse START again 2 cycles later with A=7, B=7 -> a single DONE with Q=-15, and no second DONE without a new START.
- Reset mid-operation: START with A=9, B=9; assert nRST low at cycle 3 -> BUSY=0, DONE=0, Q=0 immediately (async). After release no DONE appears until a new START.
- Asymmetric widths: WIDTH_A=8, WIDTH_B=4 with A=-128, B=-8 -> Q=+1024 (12-bit). DONE appears 5 cycles after START.
- With MULT_BOOTH_ZERO_SKIP_EN: A=0, B=-17 -> DONE in cycle t+1, Q=0, BUSY never high. Without the macro -> DONE at t+WIDTH_B+1.
